// File: rtl/note_rom_pkg.sv
// note_rom_pkg: shared constants and helpers for the note ROM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default ROM address / data widths
//   NUM_REQ_MAX / ID_W_MAX  : largest supported requester count and its index width
//   onehot_to_idx()         : one-hot vector (up to NUM_REQ_MAX bits) to binary index
package note_rom_pkg;
   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 8;
   localparam int NUM_REQ_MAX = 8;
   localparam int ID_W_MAX    = $clog2(NUM_REQ_MAX);
   function automatic logic [ID_W_MAX-1:0] onehot_to_idx(input logic [NUM_REQ_MAX-1:0] oh);
      logic [ID_W_MAX-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ_MAX; i++)
         if (oh[i]) idx = idx | ID_W_MAX'(i);
      return idx;
   endfunction
endpackage

// File: rtl/note_rom_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req    in  NUM_REQ  request vector
//   ptr    in  ID_W     highest-priority index this cycle
//   onehot out NUM_REQ  winner, first requester at or after ptr (wrapping)
//   idx    out ID_W     binary index of the winner
//   any    out 1        at least one request present
module rr_pick
   import note_rom_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   logic [NUM_REQ-1:0] w_rot;
   logic [NUM_REQ-1:0] w_rot_oh;
   // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
   assign w_rot    = NUM_REQ'({req, req} >> ptr);
   assign w_rot_oh = w_rot & (~w_rot + NUM_REQ'(1));
   assign onehot   = NUM_REQ'(({w_rot_oh, w_rot_oh} << ptr) >> NUM_REQ);
   assign idx      = ID_W'(onehot_to_idx(NUM_REQ_MAX'(onehot)));
   assign any      = |req;
endmodule

// File: rtl/note_rom_arbiter.sv
// note_rom_arbiter: round-robin sharing of one 1-cycle synchronous note ROM among NUM_REQ fetchers.
//   pixel_clk / reset_n : clock, async active-low reset
//   req / lock / addr   : per-requester request, burst-hold, address (requester i at [i*ADDR_W +: ADDR_W])
//   gnt / rom_addr      : registered one-hot grant and ROM address
//   rom_data            : ROM output, valid the cycle after rom_addr
//   rdata/rvalid/rid    : returned data, 3 cycles after the accepting edge, tagged with requester id
// Define ARB_BURST_EN to let a locked owner keep winning for up to MAX_BURST consecutive grants.
module note_rom_arbiter
   import note_rom_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 8
) (
   input  logic                        pixel_clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]           rom_addr,
   input  logic [DATA_W-1:0]           rom_data,
   output logic [DATA_W-1:0]           rdata,
   output logic                        rvalid,
   output logic [$clog2(NUM_REQ)-1:0]  rid
);
   localparam int ID_W = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] r_gnt, w_pick_oh, w_win_oh;
   logic [ADDR_W-1:0]  r_rom_addr;
   logic [DATA_W-1:0]  r_rdata;
   logic [ID_W-1:0]    r_ptr, r_id1, r_id2, r_rid, w_pick_idx, w_win_idx;
   logic               r_v1, r_v2, r_rvalid, w_pick_any, w_win, w_hold;
   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .onehot (w_pick_oh),
      .idx    (w_pick_idx),
      .any    (w_pick_any)
   );
`ifdef ARB_BURST_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   logic [CNT_W-1:0] r_cnt;
   // r_id1 is the last winner; it keeps the slot while locked and under the burst cap
   assign w_hold = req[r_id1] & lock[r_id1] & (r_cnt < CNT_W'(MAX_BURST));
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) r_cnt <= '0;
      else          r_cnt <= w_hold ? r_cnt + CNT_W'(1) : (w_pick_any ? CNT_W'(1) : '0);
   end
`else
   logic w_unused_cfg;
   assign w_hold       = 1'b0;
   assign w_unused_cfg = ^lock ^ (MAX_BURST > 0);
`endif
   assign w_win     = w_hold | w_pick_any;
   assign w_win_idx = w_hold ? r_id1 : w_pick_idx;
   assign w_win_oh  = w_hold ? NUM_REQ'(1) << r_id1 : w_pick_oh;
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gnt      <= '0;
         r_rom_addr <= '0;
         r_ptr      <= '0;
         r_id1      <= '0;
         r_id2      <= '0;
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_rid      <= '0;
      end else begin
         r_gnt <= w_win_oh;
         if (w_win) begin
            r_rom_addr <= addr[w_win_idx*ADDR_W +: ADDR_W];
            r_ptr      <= (w_win_idx == ID_W'(NUM_REQ-1)) ? '0 : w_win_idx + ID_W'(1);
            r_id1      <= w_win_idx;
         end
         // stage 1: rom_addr presented; stage 2: rom_data valid; then registered out
         r_v1     <= w_win;
         r_v2     <= r_v1;
         r_id2    <= r_id1;
         r_rvalid <= r_v2;
         if (r_v2) begin
            r_rdata <= rom_data;
            r_rid   <= r_id2;
         end
      end
   end
   assign gnt      = r_gnt;
   assign rom_addr = r_rom_addr;
   assign rdata    = r_rdata;
   assign rvalid   = r_rvalid;
   assign rid      = r_rid;
endmodule

// File: tb/tb_note_rom_arbiter.sv
// tb_note_rom_arbiter: randomized bench with a queue-based reference model for note_rom_arbiter.
module tb_note_rom_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int MB = 8;
   logic            pixel_clk = 1'b0;
   logic            reset_n   = 1'b0;
   logic [N-1:0]    req  = '0;
   logic [N-1:0]    lock = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data = '0;
   logic [DW-1:0]   rdata;
   logic            rvalid;
   logic [1:0]      rid;
   always #5 pixel_clk = ~pixel_clk;
   note_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .req       (req),
      .lock      (lock),
      .addr      (addr),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rid       (rid)
   );
   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction
   always @(posedge pixel_clk) rom_data <= rom_f(rom_addr);
   typedef struct { int due; int id; logic [DW-1:0] d; } ret_t;
   ret_t          q[$];
   int            m_ptr, m_owner, m_run, cyc;
   logic [N-1:0]  e_gnt;
   logic [AW-1:0] e_addr;
   int            errs = 0;
   int            checks = 0;
   bit            chk_en = 1'b0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge pixel_clk) begin
      bit ev;
      if (chk_en) begin
         ev = (q.size() > 0) && (q[0].due == cyc);
         chk("gnt", 32'(gnt), 32'(e_gnt));
         chk("rom_addr", 32'(rom_addr), 32'(e_addr));
         chk("rvalid", 32'(rvalid), 32'(ev));
         if (ev) begin
            chk("rid", 32'(rid), 32'(q[0].id));
            chk("rdata", 32'(rdata), 32'(q[0].d));
            void'(q.pop_front());
         end
      end
   end
   task automatic model_reset();
      q.delete();
      m_ptr = 0; m_owner = 0; m_run = 0;
      e_gnt = '0; e_addr = '0;
   endtask
   task automatic step();
      int win;
      bit hold;
      win = -1;
      hold = 1'b0;
      @(posedge pixel_clk);
      if (reset_n) begin
`ifdef ARB_BURST_EN
         hold = req[m_owner] && lock[m_owner] && (m_run < MB);
         if (hold) win = m_owner;
`endif
         if (!hold)
            for (int k = 0; k < N; k++)
               if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         if (win >= 0) begin
            e_gnt  = N'(1) << win;
            e_addr = addr[win*AW +: AW];
            m_ptr  = (win + 1) % N;
            q.push_back('{cyc + 3, win, rom_f(addr[win*AW +: AW])});
            m_run   = hold ? m_run + 1 : 1;
            m_owner = win;
         end else begin
            e_gnt = '0;
            m_run = 0;
         end
      end
      cyc++;
      @(negedge pixel_clk);
   endtask
   task automatic async_reset();
      #2 reset_n = 1'b0;
      model_reset();
   endtask
   int ng, nv;
   logic [N-1:0] g_exp [10];
   logic [N-1:0] rot [4];
   initial begin
      cyc = 0;
      model_reset();
      req = 4'hF;
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = 16'h0100 + 16'(i);
      step();
      chk_en = 1'b1;
      step(); step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rom_addr", 32'(rom_addr), 32'h0);
      reset_n = 1'b1;
      step();
      chk("first_gnt", 32'(gnt), 32'h1);
      rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rot_gnt", 32'(gnt), 32'(rot[i]));
         if (i == 1) begin
            chk("rot_rvalid0", 32'(rvalid), 32'h1);
            chk("rot_rid0", 32'(rid), 32'h0);
            chk("rot_rdata0", 32'(rdata), 32'h5B);
         end
         if (i == 2) begin
            chk("rot_rid1", 32'(rid), 32'h1);
            chk("rot_rdata1", 32'(rdata), 32'h5A);
         end
      end
      req = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i >= 2) chk("idle_rvalid", 32'(rvalid), 32'h0);
      end
      chk("idle_rom_addr", 32'(rom_addr), 32'h0100);
      req = 4'hF;
      step();
      chk("idle_ptr_kept", 32'(gnt), 32'h2);
      req = '0;
      repeat (4) step();
      req = 4'b0100;
      ng = 0; nv = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 10) req = '0;
         step();
         if (gnt == 4'b0100) ng++;
         if (rvalid && rid == 2'd2) nv++;
      end
      chk("single_gnts", 32'(ng), 32'd10);
      chk("single_rvalids", 32'(nv), 32'd10);
      req = 4'hF;
      repeat (4) step();
      async_reset();
      nv = 0;
      for (int i = 0; i < 3; i++) begin step(); nv += int'(rvalid); end
      reset_n = 1'b1;
      req = '0;
      for (int i = 0; i < 4; i++) begin step(); nv += int'(rvalid); end
      chk("reset_discard", 32'(nv), 32'd0);
      req = 4'hF;
      step();
      chk("reset_ptr0", 32'(gnt), 32'h1);
      async_reset();
      step();
      reset_n = 1'b1;
      lock = 4'b0010;
`ifdef ARB_BURST_EN
      g_exp = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4};
`else
      g_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
`endif
      for (int i = 0; i < 10; i++) begin
         step();
         chk("burst_gnt", 32'(gnt), 32'(g_exp[i]));
      end
      for (int i = 0; i < 600; i++) begin
         req  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         lock = N'($urandom);
         for (int j = 0; j < N; j++) addr[j*AW +: AW] = AW'($urandom);
         if (i == 300) begin
            async_reset();
            step();
            reset_n = 1'b1;
         end
         step();
      end
      req = '0;
      lock = '0;
      repeat (5) step();
      chk("drain_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
